// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl
// Brief   : Multiplexed 7-segment scan controller with anti-ghost blanking
//           and per-digit blink masking.
// Revision: 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scan_clk,
    input  logic                          blink_clk,
    input  logic                          enable,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel
);

    localparam int         SEL_W     = $clog2(NUM_DIGITS);
    localparam logic [7:0] BLANK_CNT = 8'(BLANK_CYCLES);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    scan_s1_q, scan_s2_q;
    logic                    blink_s1_q, blink_s2_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    scan_rise;
    logic                    blink_rise;
    logic [3:0]              nibble;

    function automatic logic [6:0] hexdec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign scan_rise  = scan_s1_q & ~scan_s2_q;
    assign blink_rise = blink_s1_q & ~blink_s2_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        blink_phase_d = blink_phase_q;

        if (blink_rise && enable) begin
            blink_phase_d = ~blink_phase_q;
        end

        // Disabling wins over every transition; the digit index is kept.
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = BLANK_CNT;
                end
                ST_BLANK: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_SHOW: begin
                    if (scan_rise) begin
                        sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_CNT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs follow the next-state values so they switch with the FSM.
    assign nibble = digits[{sel_d, 2'b00} +: 4];

    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == ST_SHOW) begin
            seg_d = hexdec(nibble);
            dp_d  = ~dp_mask[sel_d];
            if (!(blink_phase_d && blink_mask[sel_d])) begin
                an_d[sel_d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            sel_q         <= '0;
            blink_phase_q <= 1'b0;
            scan_s1_q     <= 1'b0;
            scan_s2_q     <= 1'b0;
            blink_s1_q    <= 1'b0;
            blink_s2_q    <= 1'b0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            blink_phase_q <= blink_phase_d;
            scan_s1_q     <= scan_clk;
            scan_s2_q     <= scan_s1_q;
            blink_s1_q    <= blink_clk;
            blink_s2_q    <= blink_s1_q;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_sel = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_scan_ctrl
// Brief   : Directed self-checking bench for seg_scan_ctrl (4 digits, gap 2).
// Revision: 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int BLANK = 2;

    logic        clk;
    logic        rst;
    logic        scan_clk;
    logic        blink_clk;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] sel;
    } exp_t;

    exp_t sb[$];

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_ctrl #(.NUM_DIGITS(4), .BLANK_CYCLES(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_clk   (scan_clk),
        .blink_clk  (blink_clk),
        .enable     (enable),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] a, input logic [6:0] s,
                            input logic d, input logic [1:0] sel);
        exp_t e;
        e.tag = tag; e.an = a; e.seg = s; e.dp = d; e.sel = sel;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_an"},  32'(an),        32'(e.an));
            chk({e.tag, "_seg"}, 32'(seg),       32'(e.seg));
            chk({e.tag, "_dp"},  32'(dp),        32'(e.dp));
            chk({e.tag, "_sel"}, 32'(digit_sel), 32'(e.sel));
        end
    endtask

    // Count dark cycles until a digit lights, then compare against the scoreboard.
    task automatic wait_show(input string tag, input int gap_req);
        int n = 0;
        while (an === 4'hF && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_gap"}, 32'(n), 32'(gap_req));
        pop_check();
    endtask

    task automatic scan_rise();
        scan_clk = 1'b1;
        tick();
        tick();
        scan_clk = 1'b0;
    endtask

    task automatic blink_pulse();
        blink_clk = 1'b1;
        tick();
        tick();
        blink_clk = 1'b0;
    endtask

    logic [3:0] t2_an  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] t2_seg [4] = '{7'h30, 7'h24, 7'h79, 7'h19};
    logic [1:0] t2_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst = 1'b1; enable = 1'b1; scan_clk = 1'b0; blink_clk = 1'b0;
        digits = 16'h1234; dp_mask = 4'b0000; blink_mask = 4'b0000;

        // T1: reset values, then first digit after the initial gap
        repeat (4) tick();
        push_exp("t1_rst", 4'hF, 7'h7F, 1'b1, 2'd0);
        pop_check();
        rst = 1'b0;
        tick();
        push_exp("t1_show", 4'b1110, 7'h19, 1'b1, 2'd0);
        wait_show("t1", BLANK + 1);

        // T2: four advances with wrap
        for (int i = 0; i < 4; i++) begin
            scan_rise();
            push_exp($sformatf("t2_%0d", i), t2_an[i], t2_seg[i], 1'b1, t2_sel[i]);
            wait_show($sformatf("t2_%0d", i), BLANK + 1);
        end

        // T3: blink digit 1
        blink_mask = 4'b0010;
        blink_pulse();
        push_exp("t3_d0", 4'b1110, 7'h19, 1'b1, 2'd0);
        pop_check();
        scan_rise();
        repeat (BLANK + 1) tick();
        push_exp("t3_d1_dark", 4'hF, 7'h30, 1'b1, 2'd1);
        pop_check();
        blink_pulse();
        push_exp("t3_d1_lit", 4'b1101, 7'h30, 1'b1, 2'd1);
        pop_check();
        scan_rise();
        push_exp("t3_d2", 4'b1011, 7'h24, 1'b1, 2'd2);
        wait_show("t3_d2", BLANK + 1);

        // T4: disable during digit 2, then resume on the same digit
        enable = 1'b0;
        tick();
        push_exp("t4_off", 4'hF, 7'h7F, 1'b1, 2'd2);
        pop_check();
        repeat (3) tick();
        push_exp("t4_hold", 4'hF, 7'h7F, 1'b1, 2'd2);
        pop_check();
        enable = 1'b1;
        tick();
        push_exp("t4_resume", 4'b1011, 7'h24, 1'b1, 2'd2);
        wait_show("t4", BLANK + 1);

        // T5: a second scan rise landing in BLANK is dropped
        scan_clk = 1'b1; tick();
        scan_clk = 1'b0; tick();
        scan_clk = 1'b1; tick();
        scan_clk = 1'b0;
        push_exp("t5_d3", 4'b0111, 7'h79, 1'b1, 2'd3);
        wait_show("t5", BLANK);
        repeat (6) tick();
        push_exp("t5_stay", 4'b0111, 7'h79, 1'b1, 2'd3);
        pop_check();

        // T6: reset mid-BLANK clears blink phase; then hex sweep
        blink_pulse();
        push_exp("t6_pre", 4'b0111, 7'h79, 1'b1, 2'd3);
        pop_check();
        scan_rise();
        push_exp("t6_blank", 4'hF, 7'h7F, 1'b1, 2'd0);
        pop_check();
        rst = 1'b1;
        tick();
        push_exp("t6_rst", 4'hF, 7'h7F, 1'b1, 2'd0);
        pop_check();
        rst = 1'b0;
        tick();
        push_exp("t6_d0", 4'b1110, 7'h19, 1'b1, 2'd0);
        wait_show("t6_d0", BLANK + 1);
        scan_rise();
        push_exp("t6_d1_phase0", 4'b1101, 7'h30, 1'b1, 2'd1);
        wait_show("t6_d1", BLANK + 1);

        rst = 1'b1; tick();
        rst = 1'b0; tick();
        push_exp("t6_sw0", 4'b1110, 7'h19, 1'b1, 2'd0);
        wait_show("t6_sw0", BLANK + 1);
        dp_mask = 4'b0001;
        for (int v = 0; v < 16; v++) begin
            digits = {digits[15:4], 4'(v)};
            tick();
            push_exp($sformatf("t6_hex%0h", v), 4'b1110, hex_tbl[v], 1'b0, 2'd0);
            pop_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
